// File: rtl/hello_nios2_qsys_mult_arbiter.sv
// -----------------------------------------------------------------------------
// hello_nios2_qsys_mult_arbiter
//
// Shares one pipelined 32x32->32 (low word, unsigned) multiplier cell between
// NUM_REQ requesters. A round-robin arbiter grants at most one requester per
// cycle. The granted operands are registered toward the cell. A tag
// {valid, requester id} follows each operation through a shift pipeline whose
// depth matches the cell latency, so the result can be steered back as a
// one-cycle response pulse to the right requester. Each requester may have at
// most one operation in flight.
//
// Parameters
//   NUM_REQ      number of requesters (2..8)
//   MUL_LATENCY  cell latency from operands at cell input to result (1..4)
//
// Ports
//   clk              system clock
//   reset            asynchronous active-high reset (shared with the cell)
//   req_valid        per-requester request valid
//   req_ready        per-requester grant (one-hot or zero)
//   req_src1/2       packed operands, requester i at [32*i +: 32]
//   mul_src1/2       registered operands to the multiplier cell
//   mul_cell_result  product from the multiplier cell
//   resp_valid       one-cycle response pulse for requester i
//   resp_result      product low word, zero when no response is presented
//   busy             any operation in flight
//   issue_cnt        saturating issue counter, present only when the macro
//                    MULT_ARB_ISSUE_CNT_EN is defined
// -----------------------------------------------------------------------------
module hello_nios2_qsys_mult_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_src1,
  input  logic [NUM_REQ*32-1:0] req_src2,
  output logic [31:0]           mul_src1,
  output logic [31:0]           mul_src2,
  input  logic [31:0]           mul_cell_result,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [31:0]           resp_result,
  output logic                  busy
`ifdef MULT_ARB_ISSUE_CNT_EN
  ,
  output logic [31:0]           issue_cnt
`endif
);

  localparam int DATA_W = 32;
  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH  = MUL_LATENCY + 1;

  localparam logic [PTR_W:0]   NUM_REQ_EXT = (PTR_W + 1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX    = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]  rr_ptr;
  logic [NUM_REQ-1:0] outstanding;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_any;
  logic [DATA_W-1:0] sel_src1;
  logic [DATA_W-1:0] sel_src2;

  // Tag pipeline: vld_p[s] / tag_p[s] hold the operation that has been in
  // flight for s+1 cycles; the last stage lines up with the cell output.
  logic              vld_p [DEPTH];
  logic [PTR_W-1:0]  tag_p [DEPTH];

  // No grants while reset is held, so nothing can be accepted and then lost.
  assign eligible  = req_valid & ~outstanding & {NUM_REQ{~reset}};
  assign req_ready = grant;
  assign busy      = |outstanding;

  // Round-robin search starting at rr_ptr, wrapping past the last requester.
  always_comb begin
    logic [PTR_W:0] cand;
    cand      = '0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
      if (cand >= NUM_REQ_EXT) cand = cand - NUM_REQ_EXT;
      if (!grant_any && eligible[cand[PTR_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[PTR_W-1:0];
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_src1 = '0;
    sel_src2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_src1 = req_src1[DATA_W*i +: DATA_W];
        sel_src2 = req_src2[DATA_W*i +: DATA_W];
      end
    end
  end

  // ---- Stage p0: issue (operands to cell, tag enters pipeline) ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr      <= '0;
      outstanding <= '0;
      mul_src1    <= '0;
      mul_src2    <= '0;
      for (int s = 0; s < DEPTH; s++) begin
        vld_p[s] <= 1'b0;
        tag_p[s] <= '0;
      end
    end else begin
      // A requester is never granted in its own response cycle, so the set
      // and clear terms never address the same bit on one edge.
      outstanding <= (outstanding & ~resp_valid) | grant;
      if (grant_any) begin
        rr_ptr   <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
        mul_src1 <= sel_src1;
        mul_src2 <= sel_src2;
        tag_p[0] <= grant_idx;
      end
      vld_p[0] <= grant_any;
      // ---- Stages p1..pN: tag travels alongside the cell pipeline ----
      for (int s = 1; s < DEPTH; s++) begin
        vld_p[s] <= vld_p[s-1];
        tag_p[s] <= tag_p[s-1];
      end
    end
  end

  // ---- Response: last tag stage coincides with the cell result ----
  always_comb begin
    resp_valid = '0;
    if (vld_p[DEPTH-1]) resp_valid[tag_p[DEPTH-1]] = 1'b1;
  end

  assign resp_result = (|resp_valid) ? mul_cell_result : '0;

`ifdef MULT_ARB_ISSUE_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          issue_cnt <= '0;
    else if (grant_any) issue_cnt <= sat_inc(issue_cnt);
  end
`endif

endmodule

// File: tb/tb_hello_nios2_qsys_mult_arbiter.sv
module tb_hello_nios2_qsys_mult_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int MUL_LATENCY = 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_src1;
  logic [NUM_REQ*32-1:0] req_src2;
  logic [31:0]           mul_src1;
  logic [31:0]           mul_src2;
  logic [31:0]           mul_cell_result;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [31:0]           resp_result;
  logic                  busy;
`ifdef MULT_ARB_ISSUE_CNT_EN
  logic [31:0]           issue_cnt;
`endif

  hello_nios2_qsys_mult_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .MUL_LATENCY(MUL_LATENCY)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_src1       (req_src1),
    .req_src2       (req_src2),
    .mul_src1       (mul_src1),
    .mul_src2       (mul_src2),
    .mul_cell_result(mul_cell_result),
    .resp_valid     (resp_valid),
    .resp_result    (resp_result),
    .busy           (busy)
`ifdef MULT_ARB_ISSUE_CNT_EN
    ,
    .issue_cnt      (issue_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Multiplier cell model: MUL_LATENCY register stages, same reset.
  logic [31:0] cell_p [MUL_LATENCY];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < MUL_LATENCY; s++) cell_p[s] <= '0;
    end else begin
      cell_p[0] <= mul_src1 * mul_src2;
      for (int s = 1; s < MUL_LATENCY; s++) cell_p[s] <= cell_p[s-1];
    end
  end
  assign mul_cell_result = cell_p[MUL_LATENCY-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard queues: expected grant order, response id/value, response cycle.
  int          exp_grant_q[$];
  int          exp_idx_q[$];
  logic [31:0] exp_val_q[$];
  int          lat_q[$];

  // Per-requester operand lists consumed by the driver.
  logic [31:0] pend_a [NUM_REQ][16];
  logic [31:0] pend_b [NUM_REQ][16];
  int          pend_n [NUM_REQ];
  int          pend_h [NUM_REQ];

  task automatic enq(input int i, input logic [31:0] a, input logic [31:0] b);
    pend_a[i][pend_n[i]] = a;
    pend_b[i][pend_n[i]] = b;
    pend_n[i]++;
  endtask

  task automatic expect_op(input int i, input logic [31:0] p);
    exp_grant_q.push_back(i);
    exp_idx_q.push_back(i);
    exp_val_q.push_back(p);
  endtask

  // Driver: holds valid/operands until the handshake, then presents the next.
  logic [NUM_REQ-1:0] fire_s;
  initial begin
    req_valid = '0;
    req_src1  = '0;
    req_src2  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend_n[i] = 0;
      pend_h[i] = 0;
    end
    forever begin
      @(negedge clk);
      fire_s = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (fire_s[i]) pend_h[i]++;
        if (pend_h[i] < pend_n[i]) begin
          req_valid[i]         = 1'b1;
          req_src1[32*i +: 32] = pend_a[i][pend_h[i]];
          req_src2[32*i +: 32] = pend_b[i][pend_h[i]];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: compares grants and responses against the scoreboard.
  logic [NUM_REQ-1:0] mon_fire;
  int                 mon_g;
  int                 mon_i;
  int                 mon_l;
  logic [31:0]        mon_v;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        mon_fire = req_valid & req_ready;
        if (mon_fire != '0) begin
          if (exp_grant_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL grant_unexpected: got %b expected none", mon_fire);
          end else begin
            mon_g = exp_grant_q.pop_front();
            chk("grant", 32'(mon_fire), 32'(1 << mon_g));
            lat_q.push_back(cyc + 1 + MUL_LATENCY);
          end
        end
        if (resp_valid != '0) begin
          chk("ready_in_resp", 32'(req_ready & resp_valid), 32'd0);
          if (exp_idx_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL resp_unexpected: got %b expected none", resp_valid);
          end else begin
            mon_i = exp_idx_q.pop_front();
            mon_v = exp_val_q.pop_front();
            chk("resp_valid", 32'(resp_valid), 32'(1 << mon_i));
            chk("resp_result", resp_result, mon_v);
            if (lat_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL resp_latency: got response at %0d expected no response", cyc);
            end else begin
              mon_l = lat_q.pop_front();
              chk("resp_latency", 32'(cyc), 32'(mon_l));
            end
          end
        end else begin
          chk("idle_result", resp_result, 32'd0);
        end
      end
    end
  end

  task automatic drain(input string name);
    for (int k = 0; k < 60; k++) begin
      if (exp_grant_q.size() == 0 && exp_idx_q.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (exp_grant_q.size() != 0 || exp_idx_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d grants %0d responses pending expected 0",
               name, exp_grant_q.size(), exp_idx_q.size());
      exp_grant_q.delete();
      exp_idx_q.delete();
      exp_val_q.delete();
      lat_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mul_src1", mul_src1, 32'd0);
    chk("rst_mul_src2", mul_src2, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single request, latency 1
    enq(0, 32'd3, 32'd5);
    expect_op(0, 32'd15);
    drain("t1");

    // Wrap-around products, back-to-back from one requester
    enq(1, 32'hFFFF_FFFF, 32'd2);
    enq(1, 32'h0001_0000, 32'h0001_0000);
    expect_op(1, 32'hFFFF_FFFE);
    expect_op(1, 32'h0000_0000);
    drain("t2");

    // Grant to requester 3 so the pointer wraps back to 0
    enq(3, 32'd7, 32'd9);
    expect_op(3, 32'd63);
    drain("t2b");

    // All four at once from rr_ptr=0
    enq(0, 32'd2, 32'd3);
    enq(1, 32'd4, 32'd5);
    enq(2, 32'h0000_1234, 32'h0000_0010);
    enq(3, 32'h0000_FFFF, 32'h0000_FFFF);
    expect_op(0, 32'd6);
    expect_op(1, 32'd20);
    expect_op(2, 32'h0001_2340);
    expect_op(3, 32'hFFFE_0001);
    repeat (2) @(negedge clk);
    chk("busy_inflight", 32'(busy), 32'd1);
    drain("t3");
    chk("busy_idle", 32'(busy), 32'd0);

    // Requester 0 re-requests while requester 2 waits
    enq(0, 32'd10, 32'd11);
    enq(0, 32'd12, 32'd13);
    enq(2, 32'd100, 32'd3);
    enq(2, 32'h8000_0000, 32'd2);
    expect_op(0, 32'd110);
    expect_op(2, 32'd300);
    expect_op(0, 32'd156);
    expect_op(2, 32'd0);
    drain("t4");

    // Reset one cycle after an issue: the in-flight result must vanish
    enq(1, 32'd6, 32'd7);
    exp_grant_q.push_back(1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_valid[1] && req_ready[1]) break;
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_grant_q.delete();
    exp_idx_q.delete();
    exp_val_q.delete();
    lat_q.delete();
    repeat (2) @(negedge clk);
    chk("rst2_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst2_busy", 32'(busy), 32'd0);
    chk("rst2_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Pointer back at 0: requester 1 wins over 3
    enq(3, 32'd123, 32'd456);
    enq(1, 32'h0001_0001, 32'h0001_0001);
    expect_op(1, 32'h0002_0001);
    expect_op(3, 32'd56088);
    drain("t5");
    repeat (3) @(negedge clk);

`ifdef MULT_ARB_ISSUE_CNT_EN
    chk("issue_cnt", issue_cnt, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
